// File: rtl/serial_word_deserializer_if.sv
// Serial input / parallel word output bundle for serial_word_deserializer.
// The master side drives serial bits and word acceptance; the slave side returns words and status.
interface serial_word_deserializer_if #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
);
  logic             SerialIn;
  logic             SerialValid;
  logic             DIR;
  logic             WordReady;
  logic [WIDTH-1:0] WordOut;
  logic             WordValid;
  logic [CW-1:0]    BitCount;
  logic             Overrun;

  modport master (
    output SerialIn, SerialValid, DIR, WordReady,
    input  WordOut, WordValid, BitCount, Overrun
  );

  modport slave (
    input  SerialIn, SerialValid, DIR, WordReady,
    output WordOut, WordValid, BitCount, Overrun
  );
endinterface

// File: rtl/serial_word_deserializer.sv
// Reassembles WIDTH-bit words from a one-bit-per-cycle serial stream in either bit order,
// presenting each word on a registered valid/ready output with a sticky overrun flag.
module serial_word_deserializer #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic                         clock,
  input  logic                         reset,
  serial_word_deserializer_if.slave    bus
);

  typedef enum logic {EMPTY, FULL} outState_t;

  outState_t        outState;
  logic [WIDTH-1:0] shiftReg;
  logic [CW-1:0]    bitCount;
  logic             dirQ;
  logic [WIDTH-1:0] wordReg;
  logic             overrunReg;

  logic             effDir;
  logic [WIDTH-1:0] shiftNext;
  logic             complete;

  // The first bit of a word uses the live DIR; later bits follow the direction latched then.
  always_comb begin
    effDir    = (bitCount == '0) ? bus.DIR : dirQ;
    shiftNext = effDir ? {shiftReg[WIDTH-2:0], bus.SerialIn}
                       : {bus.SerialIn, shiftReg[WIDTH-1:1]};
    complete  = bus.SerialValid && (bitCount == CW'(WIDTH - 1));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shiftReg <= '0;
      bitCount <= '0;
      dirQ     <= 1'b0;
    end else if (bus.SerialValid) begin
      shiftReg <= shiftNext;
      if (bitCount == '0)
        dirQ <= bus.DIR;
      bitCount <= complete ? '0 : bitCount + CW'(1);
    end
  end

  // A completed word is taken if the holding slot is empty or being drained on this edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outState   <= EMPTY;
      wordReg    <= '0;
      overrunReg <= 1'b0;
    end else begin
      case (outState)
        EMPTY: begin
          if (complete) begin
            wordReg  <= shiftNext;
            outState <= FULL;
          end
        end
        FULL: begin
          if (complete) begin
            if (bus.WordReady)
              wordReg <= shiftNext;
            else
              overrunReg <= 1'b1;
          end else if (bus.WordReady) begin
            outState <= EMPTY;
          end
        end
        default: outState <= EMPTY;
      endcase
    end
  end

  assign bus.WordOut   = wordReg;
  assign bus.WordValid = (outState == FULL);
  assign bus.BitCount  = bitCount;
  assign bus.Overrun   = overrunReg;

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Directed bench for serial_word_deserializer at WIDTH=4 with hand-computed expected words.
module tb_serial_word_deserializer;

  localparam int WIDTH = 4;
  localparam int CW    = $clog2(WIDTH + 1);

  logic clock;
  logic reset;
  int   total;
  int   bad;

  serial_word_deserializer_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  serial_word_deserializer #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, then returns 1 time unit after the rising edge.
  task automatic applyStimulus(input logic sin, input logic valid, input logic dir, input logic ready);
    bus.SerialIn    = sin;
    bus.SerialValid = valid;
    bus.DIR         = dir;
    bus.WordReady   = ready;
    @(posedge clock);
    #1;
  endtask

  task automatic sendWord(input logic [3:0] bits, input logic dir, input logic readyLast);
    for (int i = 0; i < 4; i++)
      applyStimulus(bits[i], 1'b1, dir, (i == 3) ? readyLast : 1'b0);
    bus.SerialValid = 1'b0;
    bus.WordReady   = 1'b0;
  endtask

  task automatic checkAll(input string tag, input logic [3:0] word, input logic valid,
                          input logic [CW-1:0] cnt, input logic ovr);
    checkOutput({tag, "_word"}, 32'(bus.WordOut), 32'(word));
    checkOutput({tag, "_valid"}, 32'(bus.WordValid), 32'(valid));
    checkOutput({tag, "_count"}, 32'(bus.BitCount), 32'(cnt));
    checkOutput({tag, "_ovr"}, 32'(bus.Overrun), 32'(ovr));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.SerialIn    = 1'b1;
    bus.SerialValid = 1'b1;
    bus.DIR         = 1'b1;
    bus.WordReady   = 1'b1;

    // Junk inputs while reset is held must not move any state.
    @(posedge clock);
    #1;
    checkAll("rst_hold", 4'h0, 1'b0, '0, 1'b0);
    reset = 1'b0;
    bus.SerialValid = 1'b0;
    bus.WordReady   = 1'b0;

    // LSB first: bits 1,0,1,1 -> 4'hD
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("lsb_partial_count", 32'(bus.BitCount), 32'd2);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkAll("lsb", 4'hD, 1'b1, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("consume_valid", 32'(bus.WordValid), 32'd0);
    checkOutput("consume_hold_word", 32'(bus.WordOut), 32'hD);

    // MSB first: bits 1,0,1,1 -> 4'hB
    sendWord(4'b1101, 1'b1, 1'b0);
    checkAll("msb", 4'hB, 1'b1, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    // LSB-first 4'h6 with 3 idle cycles between bits and DIR flipped after bit 0.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(((4'h6 >> i) & 4'h1) != 0, 1'b1, (i != 0), 1'b0);
      if (i < 3)
        for (int g = 0; g < 3; g++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      if (i == 1) checkOutput("gap_count", 32'(bus.BitCount), 32'd2);
    end
    bus.SerialValid = 1'b0;
    checkAll("gap", 4'h6, 1'b1, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    // New word with DIR=1: bits 0,0,1,1 MSB first -> 4'h3
    sendWord(4'b1100, 1'b1, 1'b0);
    checkAll("msb_after_gap", 4'h3, 1'b1, '0, 1'b0);

    // Consume 4'h3 on the very edge that completes LSB-first 4'hC.
    sendWord(4'hC, 1'b0, 1'b1);
    checkAll("simul", 4'hC, 1'b1, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("simul_drain", 32'(bus.WordValid), 32'd0);

    // Overrun: 4'hA then 4'h5 back-to-back with WordReady low.
    sendWord(4'hA, 1'b0, 1'b0);
    checkAll("ovr_first", 4'hA, 1'b1, '0, 1'b0);
    sendWord(4'h5, 1'b0, 1'b0);
    checkAll("ovr", 4'hA, 1'b1, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    bus.WordReady = 1'b0;
    checkAll("ovr_drain", 4'hA, 1'b0, '0, 1'b1);

    // Reset mid-word after 2 bits, asserted between edges.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("pre_rst_count", 32'(bus.BitCount), 32'd2);
    reset = 1'b1;
    #2;
    checkAll("rst_async", 4'h0, 1'b0, '0, 1'b0);
    bus.SerialValid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Fresh LSB-first bits 0,1,1,0 -> 4'h6 with no stale bits.
    sendWord(4'h6, 1'b0, 1'b0);
    checkAll("post_rst", 4'h6, 1'b1, '0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
